// File: rtl/adder_accumulate_ctrl_if.sv
// Operand, control and status bundle between the front panel / adder chain and
// the accumulate controller. The master side drives the switches, buttons and
// returned sum. The slave side is the controller.
interface adder_accumulate_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] Switches;
  logic             LoadB;
  logic             Run;
  logic [WIDTH-1:0] Sum_in;
  logic             Cout_in;
  logic [WIDTH-1:0] A_out;
  logic [WIDTH-1:0] B_out;
  logic             Cout_out;
  logic             Busy;
  logic             Done;

  modport master (
    output Switches, LoadB, Run, Sum_in, Cout_in,
    input  A_out, B_out, Cout_out, Busy, Done
  );

  modport slave (
    input  Switches, LoadB, Run, Sum_in, Cout_in,
    output A_out, B_out, Cout_out, Busy, Done
  );
endinterface

// File: rtl/adder_accumulate_ctrl.sv
// Register/control stage in front of the carry-select adder chain.
// It holds the accumulator A and the operand B, and presents both to the adder.
// On each Run press it waits SETTLE_CYCLES for the sum to settle, then writes Sum/Cout back into A.
// HOLD state: after a write, the controller waits here for Run to be released, so one press gives one accumulate.
module adder_accumulate_ctrl #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input logic                   Clk,
  input logic                   Reset,
  adder_accumulate_ctrl_if.slave bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cout_q, cout_d;
  logic             run_q;
  logic             runRise;

  assign runRise = bus.Run & ~run_q;

  // Next-state and register-update decode; A/B only change in IDLE (B) or LATCH (A)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (runRise) begin
          state_d = ADD;
          cnt_d   = SETTLE_INIT;
        end else if (bus.LoadB) begin
          b_d = bus.Switches;
        end
      end
      ADD: begin
        if (cnt_q == '0) begin
          state_d = LATCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LATCH: begin
        a_d     = bus.Sum_in;
        cout_d  = bus.Cout_in;
        state_d = bus.Run ? HOLD : IDLE;
      end
      HOLD: begin
        if (!bus.Run) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, operand and Run-edge registers; synchronous reset aborts any accumulate in flight
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cout_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cout_q  <= cout_d;
      run_q   <= bus.Run;
    end
  end

  assign bus.A_out    = a_q;
  assign bus.B_out    = b_q;
  assign bus.Cout_out = cout_q;
  assign bus.Busy     = (state_q == ADD) || (state_q == LATCH);
  assign bus.Done     = (state_q == LATCH);

endmodule

// File: tb/tb_adder_accumulate_ctrl.sv
// Bench for adder_accumulate_ctrl: a behavioural model tracks the accumulator,
// B, the carry and how many busy cycles remain. A compare process checks every cycle.
// The directed scenarios and the randomized traffic pin the model with literal values.
module tb_adder_accumulate_ctrl;

  localparam int WIDTH  = 16;
  localparam int SETTLE = 2;

  logic Clk;
  logic Reset;
  adder_accumulate_ctrl_if #(.WIDTH(WIDTH)) bus ();

  adder_accumulate_ctrl #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // The adder chain modelled as an ideal combinational adder
  assign {bus.Cout_in, bus.Sum_in} = {1'b0, bus.A_out} + {1'b0, bus.B_out};

  int totalChecks = 0;
  int badChecks   = 0;

  // Model state: accumulator, B, carry, busy cycles remaining, waiting-for-release flag
  logic [WIDTH-1:0] mA, mB;
  logic             mC;
  int               busyLeft;
  bit               holding;
  bit               runPrev;
  bit               modelValid = 1'b0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: one press equals SETTLE+1 busy cycles, then A = A + B with the carry split off
  always @(posedge Clk) begin
    if (Reset) begin
      mA = '0; mB = '0; mC = 1'b0;
      busyLeft = 0; holding = 1'b0; runPrev = 1'b0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      if (busyLeft > 0) begin
        if (busyLeft == 1) begin
          {mC, mA} = {1'b0, mA} + {1'b0, mB};
          holding  = bus.Run;
        end
        busyLeft--;
      end else if (holding) begin
        if (!bus.Run) holding = 1'b0;
      end else if (bus.Run && !runPrev) begin
        busyLeft = SETTLE + 1;
      end else if (bus.LoadB) begin
        mB = bus.Switches;
      end
      runPrev = bus.Run;
    end
  end

  // Compare every DUT output against the model midway between rising edges
  always @(negedge Clk) begin
    if (modelValid) begin
      checkOutput("A_out",    32'(bus.A_out),    32'(mA));
      checkOutput("B_out",    32'(bus.B_out),    32'(mB));
      checkOutput("Cout_out", 32'(bus.Cout_out), 32'(mC));
      checkOutput("Busy",     32'(bus.Busy),     32'(busyLeft > 0));
      checkOutput("Done",     32'(bus.Done),     32'(busyLeft == 1));
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input bit run, input bit loadB, input logic [WIDTH-1:0] sw);
    bus.Run      = run;
    bus.LoadB    = loadB;
    bus.Switches = sw;
  endtask

  task automatic loadOperand(input logic [WIDTH-1:0] value);
    applyStimulus(1'b0, 1'b1, value);
    @(negedge Clk);
    applyStimulus(1'b0, 1'b0, value);
  endtask

  // Press Run for holdCycles cycles, then release it and wait (bounded) until the controller is idle; counts Done pulses
  task automatic pressRun(input int holdCycles, input bit loadDuring, output int doneCnt);
    int waitCnt;
    doneCnt = 0;
    bus.Run = 1'b1;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge Clk);
      if (!loadDuring) bus.LoadB = 1'b0;
      if (bus.Done) doneCnt++;
    end
    bus.Run = 1'b0;
    waitCnt = 0;
    do begin
      @(negedge Clk);
      if (bus.Done) doneCnt++;
      waitCnt++;
    end while ((bus.Busy || bus.Done) && waitCnt < 40);
    bus.LoadB = 1'b0;
    if (waitCnt >= 40) checkOutput("idleTimeout", 32'd0, 32'd1);
    @(negedge Clk);
  endtask

  initial begin
    int  doneCnt;
    bit  runLevel;
    logic [WIDTH-1:0] sw;

    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    repeat (2) @(negedge Clk);
    checkOutput("resetA",    32'(bus.A_out), 32'h0);
    checkOutput("resetBusy", 32'(bus.Busy),  32'h0);
    checkOutput("resetDone", 32'(bus.Done),  32'h0);
    Reset = 1'b0;

    // Load B=3, single-cycle Run pulse, exact latency of Done and the write-back
    loadOperand(16'h0003);
    checkOutput("loadB3", 32'(bus.B_out), 32'h0003);
    bus.Run = 1'b1;
    @(negedge Clk);
    bus.Run = 1'b0;
    repeat (SETTLE) @(negedge Clk);
    checkOutput("latencyDone",  32'(bus.Done),  32'h1);
    checkOutput("latencyAold",  32'(bus.A_out), 32'h0000);
    @(negedge Clk);
    checkOutput("latencyDoneOff", 32'(bus.Done),  32'h0);
    checkOutput("firstAccum",     32'(bus.A_out), 32'h0003);
    @(negedge Clk);

    // Run held 20 cycles: one accumulate, then HOLD ignores LoadB
    doneCnt = 0;
    bus.Run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (i == 10) begin bus.LoadB = 1'b1; bus.Switches = 16'h00FF; end
      if (bus.Done) doneCnt++;
    end
    checkOutput("holdDoneCount", 32'(doneCnt),      32'd1);
    checkOutput("holdA",         32'(bus.A_out),    32'h0006);
    checkOutput("holdBusy",      32'(bus.Busy),     32'h0);
    checkOutput("holdBfrozen",   32'(bus.B_out),    32'h0003);
    bus.LoadB = 1'b0;
    bus.Run   = 1'b0;
    repeat (2) @(negedge Clk);

    // Drive A to 0xFFFF, then overflow into the carry, then clear the carry
    loadOperand(16'hFFF9);
    pressRun(1, 1'b0, doneCnt);
    checkOutput("toFFFF",    32'(bus.A_out),    32'hFFFF);
    checkOutput("toFFFFc",   32'(bus.Cout_out), 32'h0);
    loadOperand(16'h0001);
    pressRun(1, 1'b0, doneCnt);
    checkOutput("wrapA",     32'(bus.A_out),    32'h0000);
    checkOutput("wrapCout",  32'(bus.Cout_out), 32'h1);
    checkOutput("wrapDones", 32'(doneCnt),      32'd1);
    pressRun(3, 1'b0, doneCnt);
    checkOutput("afterWrapA", 32'(bus.A_out),    32'h0001);
    checkOutput("afterWrapC", 32'(bus.Cout_out), 32'h0);

    // Run rise and LoadB together: Run wins, B unchanged
    bus.LoadB = 1'b1; bus.Switches = 16'h1234;
    pressRun(1, 1'b0, doneCnt);
    checkOutput("collideB", 32'(bus.B_out), 32'h0001);
    checkOutput("collideA", 32'(bus.A_out), 32'h0002);

    // LoadB held through ADD: ignored; loaded only once back in IDLE
    bus.LoadB = 1'b1; bus.Switches = 16'h00FF;
    @(negedge Clk);
    bus.LoadB = 1'b0;
    checkOutput("preloadB", 32'(bus.B_out), 32'h00FF);
    loadOperand(16'h0001);
    bus.Switches = 16'h00FF;
    bus.Run = 1'b1;
    @(negedge Clk);
    bus.LoadB = 1'b1;
    pressRun(1, 1'b1, doneCnt);
    checkOutput("addLoadIgnored", 32'(bus.B_out), 32'h0001);
    loadOperand(16'h00FF);
    checkOutput("idleLoadFF", 32'(bus.B_out), 32'h00FF);

    // Reset during ADD with the counter still nonzero aborts the accumulate
    bus.Run = 1'b1;
    @(negedge Clk);
    checkOutput("abortInAdd", 32'(bus.Busy), 32'h1);
    bus.Run = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checkOutput("abortA",    32'(bus.A_out), 32'h0);
    checkOutput("abortB",    32'(bus.B_out), 32'h0);
    checkOutput("abortBusy", 32'(bus.Busy),  32'h0);
    repeat (SETTLE + 2) begin
      @(negedge Clk);
      checkOutput("abortNoDone", 32'(bus.Done), 32'h0);
    end

    // Randomized traffic, including resets and Run held through reset
    runLevel = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 4) == 0) runLevel = ~runLevel;
      case ($urandom_range(0, 3))
        0:       sw = 16'hFFFF;
        1:       sw = 16'(($urandom_range(0, 15)));
        default: sw = 16'($urandom);
      endcase
      Reset = ($urandom_range(0, 149) == 0);
      applyStimulus(runLevel, ($urandom_range(0, 2) == 0), sw);
      @(negedge Clk);
    end
    Reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0);
    repeat (SETTLE + 3) @(negedge Clk);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
